move_controller: RTL and testbench

Turn-based move sequencer for the 7x7 gomoku board. It converts cursor and place buttons into single-cycle `go` writes with `x`, `y` and `color` for the board/win-check block, and rejects moves on occupied cells. It samples the returned win `state` after each write and handles win, draw and restart. It sits between the input synchroniser and the board; the top level drives the board's active-low clear as ~(reset | clear).

---
 rtl/move_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_move_controller.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_controller.sv
// move_controller
// Turn-based move sequencer for the NxN gomoku board. Converts cursor and
// place buttons into one-cycle board writes, refuses occupied cells and runs
// the win / draw / restart flow around the result returned by the board.
module move_controller #(
   parameter int N     = 7,
   parameter int CELLS = N * N
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_place,
   input  logic [1:0] state,
   output logic       go,
   output logic [2:0] x,
   output logic [2:0] y,
   output logic       color,
   output logic       reject,
   output logic       clear,
   output logic       game_over,
   output logic [1:0] winner,
   output logic [5:0] move_count
);

   typedef enum logic [2:0] {
      PLAY   = 3'd0,
      COMMIT = 3'd1,
      EVAL   = 3'd2,
      OVER   = 3'd3,
      CLEAR  = 3'd4
   } fsm_t;

   localparam logic [2:0] HOME  = 3'd3;
   localparam logic [2:0] LAST  = 3'(N - 1);
   localparam logic [5:0] FULL  = 6'(CELLS);
   localparam logic [5:0] ROW_W = 6'(N);

   fsm_t             fsm_r;
   fsm_t             fsm_s;
   logic [4:0]       btn_s;
   logic [4:0]       btn_q_r;
   logic [4:0]       rise_s;
   logic [CELLS-1:0] occ_r;
   logic [CELLS-1:0] occ_s;
   logic [5:0]       cell_s;
   logic             busy_s;
   logic [1:0]       result_s;
   logic [2:0]       x_r;
   logic [2:0]       x_s;
   logic [2:0]       y_r;
   logic [2:0]       y_s;
   logic             color_r;
   logic             color_s;
   logic [5:0]       count_r;
   logic [5:0]       count_s;
   logic [1:0]       winner_r;
   logic [1:0]       winner_s;
   logic             go_r;
   logic             go_s;
   logic             reject_r;
   logic             reject_s;
   logic             clear_r;
   logic             clear_s;
   logic             over_r;
   logic             over_s;

   // One wrapping step along an axis; opposing requests cancel.
   function automatic logic [2:0] step_axis(input logic [2:0] pos,
                                            input logic       inc,
                                            input logic       dec);
      logic [2:0] res;
      if (inc && !dec) begin
         res = (pos == LAST) ? 3'd0 : pos + 3'd1;
      end else if (dec && !inc) begin
         res = (pos == 3'd0) ? LAST : pos - 3'd1;
      end else begin
         res = pos;
      end
      return res;
   endfunction

   // Bit order: [4] place, [3] up, [2] down, [1] left, [0] right.
   assign btn_s    = {btn_place, btn_up, btn_down, btn_left, btn_right};
   assign rise_s   = btn_s & ~btn_q_r;
   assign cell_s   = (6'(y_r) * ROW_W) + 6'(x_r);
   assign busy_s   = occ_r[cell_s];
   // The board never legitimately reports 3; treat it as "no winner".
   assign result_s = (state == 2'd3) ? 2'd0 : state;

   assign go         = go_r;
   assign x          = x_r;
   assign y          = y_r;
   assign color      = color_r;
   assign reject     = reject_r;
   assign clear      = clear_r;
   assign game_over  = over_r;
   assign winner     = winner_r;
   assign move_count = count_r;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_r <= PLAY;
      end else begin
         fsm_r <= fsm_s;
      end
   end

   // Next-state decision: buttons only matter in PLAY and OVER.
   always_comb begin
      fsm_s = fsm_r;
      case (fsm_r)
         PLAY: begin
            if (rise_s[4] && !busy_s) begin
               fsm_s = COMMIT;
            end else begin
               fsm_s = PLAY;
            end
         end
         COMMIT: fsm_s = EVAL;
         EVAL: begin
            if ((result_s != 2'd0) || (count_r == FULL)) begin
               fsm_s = OVER;
            end else begin
               fsm_s = PLAY;
            end
         end
         OVER: begin
            if (rise_s[4]) begin
               fsm_s = CLEAR;
            end else begin
               fsm_s = OVER;
            end
         end
         CLEAR:   fsm_s = PLAY;
         default: fsm_s = PLAY;
      endcase
   end

   // Next values of the datapath and of every (registered) output.
   always_comb begin
      x_s      = x_r;
      y_s      = y_r;
      color_s  = color_r;
      occ_s    = occ_r;
      count_s  = count_r;
      winner_s = winner_r;
      reject_s = 1'b0;
      go_s     = (fsm_s == COMMIT);
      clear_s  = (fsm_s == CLEAR);
      over_s   = (fsm_s == OVER);
      case (fsm_r)
         PLAY: begin
            if (rise_s[4]) begin
               // A place attempt suppresses any cursor motion in the same cycle.
               reject_s = busy_s;
            end else begin
               x_s = step_axis(x_r, rise_s[0], rise_s[1]);
               y_s = step_axis(y_r, rise_s[2], rise_s[3]);
            end
         end
         COMMIT: begin
            occ_s[cell_s] = 1'b1;
            count_s       = count_r + 6'd1;
         end
         EVAL: begin
            if (result_s != 2'd0) begin
               winner_s = result_s;
            end else if (count_r == FULL) begin
               winner_s = 2'd0;
            end else begin
               color_s = ~color_r;
            end
         end
         OVER: begin
            // Frozen until a place rise requests a restart.
         end
         CLEAR: begin
            occ_s    = {CELLS{1'b0}};
            count_s  = 6'd0;
            color_s  = 1'b0;
            x_s      = HOME;
            y_s      = HOME;
            winner_s = 2'd0;
         end
         default: begin
            occ_s = occ_r;
         end
      endcase
   end

   // Datapath and output registers, including the button edge-detect stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_q_r  <= 5'd0;
         occ_r    <= {CELLS{1'b0}};
         x_r      <= HOME;
         y_r      <= HOME;
         color_r  <= 1'b0;
         count_r  <= 6'd0;
         winner_r <= 2'd0;
         go_r     <= 1'b0;
         reject_r <= 1'b0;
         clear_r  <= 1'b0;
         over_r   <= 1'b0;
      end else begin
         btn_q_r  <= btn_s;
         occ_r    <= occ_s;
         x_r      <= x_s;
         y_r      <= y_s;
         color_r  <= color_s;
         count_r  <= count_s;
         winner_r <= winner_s;
         go_r     <= go_s;
         reject_r <= reject_s;
         clear_r  <= clear_s;
         over_r   <= over_s;
      end
   end

endmodule

// File: tb/tb_move_controller.sv
// tb_move_controller
// Self-checking bench for move_controller: randomized cursor/place stimulus
// against a cell-array game model, plus a small board model that writes on go
// and reports five-in-a-row wins back through `state`.
module tb_move_controller;

   localparam int N     = 7;
   localparam int CELLS = 49;

   typedef int board_t [0:6][0:6];

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_up, btn_down, btn_left, btn_right, btn_place;
   logic [1:0] state;
   logic       go;
   logic [2:0] x, y;
   logic       color, reject, clear, game_over;
   logic [1:0] winner;
   logic [5:0] move_count;

   int checks   = 0;
   int failures = 0;

   // game model
   int     m_x, m_y, m_color, m_mc, m_over, m_winner;
   board_t m_board;

   // board environment
   board_t     env_board;
   logic       board_en  = 1'b0;
   logic       force_en  = 1'b0;
   logic [1:0] force_val = 2'd0;
   int         go_seen   = 0;

   move_controller #(.N(N), .CELLS(CELLS)) dut (
      .clk(clk), .reset(reset),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .btn_place(btn_place), .state(state),
      .go(go), .x(x), .y(y), .color(color), .reject(reject), .clear(clear),
      .game_over(game_over), .winner(winner), .move_count(move_count)
   );

   always #5 clk = ~clk;

   // Colour (1 black, 2 white) owning any five-in-a-row, else 0.
   function automatic int five_in_row(input board_t b);
      int dr, dc, run, rr, cc;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if (b[r][c] != 0) begin
               for (int d = 0; d < 4; d++) begin
                  dr  = (d == 0) ? 0 : 1;
                  dc  = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
                  run = 0;
                  for (int k = 0; k < 5; k++) begin
                     rr = r + k * dr;
                     cc = c + k * dc;
                     if (rr >= 0 && rr < N && cc >= 0 && cc < N) begin
                        if (b[rr][cc] == b[r][c]) run++;
                     end
                  end
                  if (run == 5) return b[r][c];
               end
            end
         end
      end
      return 0;
   endfunction

   // Board: written at the edge that ends a go cycle, cleared by reset or clear.
   always @(posedge clk) begin
      if (reset || clear) begin
         for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++)
               env_board[r][c] <= 0;
      end else if (go) begin
         env_board[y][x] <= color ? 2 : 1;
      end
      if (go) go_seen <= go_seen + 1;
   end

   // Win result returned to the controller.
   always_comb begin
      if (force_en) state = force_val;
      else if (board_en) state = 2'(five_in_row(env_board));
      else state = 2'd0;
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_x = 3; m_y = 3; m_color = 0; m_mc = 0; m_over = 0; m_winner = 0;
      for (int r = 0; r < 7; r++)
         for (int c = 0; c < 7; c++)
            m_board[r][c] = 0;
   endtask

   task automatic apply_reset();
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_place = 1'b0;
      board_en = 1'b0; force_en = 1'b0;
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      model_reset();
   endtask

   task automatic press_dirs(input logic u, input logic d, input logic l, input logic r);
      btn_up = u; btn_down = d; btn_left = l; btn_right = r;
      step();
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      step();
      if (m_over == 0) begin
         m_x = (m_x + int'(r) - int'(l) + N) % N;
         m_y = (m_y + int'(d) - int'(u) + N) % N;
      end
   endtask

   task automatic move_to(input int tx, input int ty);
      for (int i = 0; i < N && m_x != tx; i++) press_dirs(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < N && m_y != ty; i++) press_dirs(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   // One place press in PLAY, checked at t+1, t+2 and t+3.
   task automatic do_place(input string tag);
      logic acc;
      int   w;
      acc = (m_board[m_y][m_x] == 0);
      btn_place = 1'b1;
      step();
      btn_place = 1'b0;
      checks++;
      if ({go, reject, x, y, color} !== {acc, ~acc, 3'(m_x), 3'(m_y), 1'(m_color)}) begin
         failures++;
         $display("FAIL %s_strobe: got go=%0b reject=%0b x=%0d y=%0d color=%0b, want go=%0b reject=%0b x=%0d y=%0d color=%0d",
                  tag, go, reject, x, y, color, acc, ~acc, m_x, m_y, m_color);
      end
      step();
      if (acc) begin
         m_board[m_y][m_x] = m_color + 1;
         m_mc++;
      end
      checks++;
      if ({go, reject, move_count} !== {2'b00, 6'(m_mc)}) begin
         failures++;
         $display("FAIL %s_after: got go=%0b reject=%0b move_count=%0d, want go=0 reject=0 move_count=%0d",
                  tag, go, reject, move_count, m_mc);
      end
      step();
      if (acc) begin
         w = board_en ? five_in_row(m_board) : 0;
         if (w != 0) begin
            m_over = 1; m_winner = w;
         end else if (m_mc == CELLS) begin
            m_over = 1; m_winner = 0;
         end else begin
            m_color = 1 - m_color;
         end
      end
      checks++;
      if ({go, game_over, winner, color, move_count} !== {1'b0, 1'(m_over), 2'(m_winner), 1'(m_color), 6'(m_mc)}) begin
         failures++;
         $display("FAIL %s_settle: got go=%0b game_over=%0b winner=%0d color=%0b move_count=%0d, want go=0 game_over=%0d winner=%0d color=%0d move_count=%0d",
                  tag, go, game_over, winner, color, move_count, m_over, m_winner, m_color, m_mc);
      end
   endtask

   // Restart from OVER: clear pulse, then PLAY with reset values.
   task automatic restart_from_over(input string tag);
      btn_place = 1'b1;
      step();
      btn_place = 1'b0;
      checks++;
      if ({clear, go, game_over} !== 3'b100) begin
         failures++;
         $display("FAIL %s_clear_pulse: got clear=%0b go=%0b game_over=%0b, want clear=1 go=0 game_over=0", tag, clear, go, game_over);
      end
      step();
      model_reset();
      checks++;
      if ({clear, go, reject, game_over, winner, color, x, y, move_count} !== {4'b0000, 2'd0, 1'b0, 3'd3, 3'd3, 6'd0}) begin
         failures++;
         $display("FAIL %s_restart: got clear=%0b go=%0b reject=%0b game_over=%0b winner=%0d color=%0b x=%0d y=%0d move_count=%0d, want all zero with x=3 y=3",
                  tag, clear, go, reject, game_over, winner, color, x, y, move_count);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({go, reject, clear, game_over, winner, color, x, y, move_count} !== {4'b0000, 2'd0, 1'b0, 3'd3, 3'd3, 6'd0}) begin
            failures++;
            $display("FAIL reset_values: got go=%0b reject=%0b clear=%0b game_over=%0b winner=%0d color=%0b x=%0d y=%0d move_count=%0d, want zeros with x=3 y=3",
                     go, reject, clear, game_over, winner, color, x, y, move_count);
         end
         step();
      end
   endtask

   task automatic test_cursor();
      int g0, m;
      apply_reset();
      step();
      g0 = go_seen;
      for (int i = 0; i < 4; i++) press_dirs(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({x, y} !== {3'd0, 3'd3}) begin
         failures++;
         $display("FAIL cursor_right_wrap: got x=%0d y=%0d, want x=0 y=3", x, y);
      end
      for (int i = 0; i < 4; i++) press_dirs(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({x, y} !== {3'd0, 3'd6}) begin
         failures++;
         $display("FAIL cursor_up_wrap: got x=%0d y=%0d, want x=0 y=6", x, y);
      end
      for (int i = 0; i < 30; i++) begin
         m = int'($urandom_range(0, 15));
         press_dirs(m[3], m[2], m[1], m[0]);
         checks++;
         if ({x, y} !== {3'(m_x), 3'(m_y)}) begin
            failures++;
            $display("FAIL cursor_random_%0d: got x=%0d y=%0d, want x=%0d y=%0d", i, x, y, m_x, m_y);
         end
      end
      checks++;
      if (go_seen !== g0) begin
         failures++;
         $display("FAIL cursor_no_go: got %0d go pulses, want 0", go_seen - g0);
      end
   endtask

   task automatic test_place_reject();
      apply_reset();
      do_place("place_33");
      checks++;
      if ({color, move_count} !== {1'b1, 6'd1}) begin
         failures++;
         $display("FAIL place_33_turn: got color=%0b move_count=%0d, want color=1 move_count=1", color, move_count);
      end
      do_place("replace_33");
   endtask

   task automatic test_cancel();
      int px, py;
      px = m_x; py = m_y;
      press_dirs(1'b0, 1'b1, 1'b1, 1'b1);
      checks++;
      if ({x, y} !== {3'(px), 3'((py + 1) % N)}) begin
         failures++;
         $display("FAIL cancel_lr: got x=%0d y=%0d, want x=%0d y=%0d", x, y, px, (py + 1) % N);
      end
      px = m_x; py = m_y;
      press_dirs(1'b1, 1'b1, 1'b0, 1'b1);
      checks++;
      if ({x, y} !== {3'((px + 1) % N), 3'(py)}) begin
         failures++;
         $display("FAIL cancel_ud: got x=%0d y=%0d, want x=%0d y=%0d", x, y, (px + 1) % N, py);
      end
   endtask

   task automatic test_back_to_back();
      int g0;
      apply_reset();
      move_to(1, 1);
      btn_place = 1'b1;
      step();
      btn_place = 1'b0;
      btn_right = 1'b1;      // rises during COMMIT, must be dropped
      step(); step(); step();
      btn_right = 1'b0;
      step();
      m_board[1][1] = 1; m_mc = 1; m_color = 1;
      checks++;
      if ({x, y, color, move_count} !== {3'd1, 3'd1, 1'b1, 6'd1}) begin
         failures++;
         $display("FAIL dropped_rise: got x=%0d y=%0d color=%0b move_count=%0d, want x=1 y=1 color=1 move_count=1", x, y, color, move_count);
      end
      press_dirs(1'b0, 1'b0, 1'b0, 1'b1);
      do_place("b2b_first");
      do_place("b2b_again");  // immediate retry on the same cell
      // held place button: a single action
      press_dirs(1'b0, 1'b1, 1'b0, 1'b0);
      g0 = go_seen;
      btn_place = 1'b1;
      for (int i = 0; i < 6; i++) step();
      btn_place = 1'b0;
      step();
      m_board[m_y][m_x] = m_color + 1; m_mc++; m_color = 1 - m_color;
      checks++;
      if ((go_seen - g0) !== 1 || {color, move_count} !== {1'(m_color), 6'(m_mc)}) begin
         failures++;
         $display("FAIL held_place: got %0d go pulses color=%0b move_count=%0d, want 1 pulse color=%0d move_count=%0d",
                  go_seen - g0, color, move_count, m_color, m_mc);
      end
   endtask

   task automatic test_random_play();
      int m;
      apply_reset();
      for (int i = 0; i < 25; i++) begin
         m = int'($urandom_range(0, 15));
         press_dirs(m[3], m[2], m[1], m[0]);
         checks++;
         if ({x, y} !== {3'(m_x), 3'(m_y)}) begin
            failures++;
            $display("FAIL rand_cursor_%0d: got x=%0d y=%0d, want x=%0d y=%0d", i, x, y, m_x, m_y);
         end
         if ($urandom_range(0, 1) == 1) do_place($sformatf("rand_place_%0d", i));
      end
   endtask

   task automatic test_state3();
      apply_reset();
      force_en  = 1'b1;
      force_val = 2'd3;
      do_place("state3");
      force_en  = 1'b0;
   endtask

   task automatic test_win();
      apply_reset();
      board_en = 1'b1;
      for (int k = 0; k < 9; k++) begin
         move_to(k / 2, (k % 2 == 0) ? 0 : 6);
         do_place($sformatf("win_move_%0d", k));
      end
      checks++;
      if ({game_over, winner, color} !== {1'b1, 2'd1, 1'b0}) begin
         failures++;
         $display("FAIL win_result: got game_over=%0b winner=%0d color=%0b, want game_over=1 winner=1 color=0", game_over, winner, color);
      end
      press_dirs(1'b1, 1'b0, 1'b1, 1'b0);
      press_dirs(1'b0, 1'b1, 1'b0, 1'b1);
      checks++;
      if ({x, y, color, game_over} !== {3'd4, 3'd0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL over_frozen: got x=%0d y=%0d color=%0b game_over=%0b, want x=4 y=0 color=0 game_over=1", x, y, color, game_over);
      end
      restart_from_over("win");
      board_en = 1'b0;
   endtask

   task automatic test_fill();
      apply_reset();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            move_to(c, r);
            do_place($sformatf("fill_%0d_%0d", c, r));
         end
      checks++;
      if ({game_over, winner, move_count} !== {1'b1, 2'd0, 6'd49}) begin
         failures++;
         $display("FAIL fill_draw: got game_over=%0b winner=%0d move_count=%0d, want game_over=1 winner=0 move_count=49", game_over, winner, move_count);
      end
      press_dirs(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({x, y} !== {3'd6, 3'd6}) begin
         failures++;
         $display("FAIL fill_frozen: got x=%0d y=%0d, want x=6 y=6", x, y);
      end
      restart_from_over("fill");
   endtask

   task automatic test_reset_eval();
      apply_reset();
      btn_place = 1'b1;
      step();
      btn_place = 1'b0;
      checks++;
      if (go !== 1'b1) begin
         failures++;
         $display("FAIL reset_eval_go: got go=%0b, want 1", go);
      end
      step();                 // now in EVAL
      reset = 1'b1;
      step();
      reset = 1'b0;
      model_reset();
      checks++;
      if ({go, reject, clear, game_over, winner, color, x, y, move_count} !== {4'b0000, 2'd0, 1'b0, 3'd3, 3'd3, 6'd0}) begin
         failures++;
         $display("FAIL reset_eval: got go=%0b reject=%0b clear=%0b game_over=%0b winner=%0d color=%0b x=%0d y=%0d move_count=%0d, want zeros with x=3 y=3",
                  go, reject, clear, game_over, winner, color, x, y, move_count);
      end
   endtask

   initial begin
      test_reset();
      test_cursor();
      test_place_reject();
      test_cancel();
      test_back_to_back();
      test_random_play();
      test_state3();
      test_win();
      test_fill();
      test_reset_eval();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
